sram_1r1w: RTL and testbench
============================

Name: sram_1r1w

Overview:
- Single-clock memory with one asynchronous (combinational) read port and one synchronous write port.
- Serves as the Output Memory of the Bellman-Ford engine: holds per-node distance/predecessor words written by the engine and read back by it.
- Read-only siblings (one- and two-read-port variants) share the same storage model and preload convention.

Parameters:
- DATA_WIDTH, 16, width of each word and of WriteBus/ReadBus.
- ADDR_WIDTH, 13, width of WriteAddress/ReadAddress.
- DEPTH, 8192 (2**ADDR_WIDTH), number of words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clock  input  1  sole clock; writes occur on its rising edge.
- reset  input  1  asynchronous, active-high; clears the array.
- WE  input  1  write enable, sampled at the rising clock edge.
- WriteAddress  input  ADDR_WIDTH  word address for writes.
- WriteBus  input  DATA_WIDTH  write data.
- ReadAddress  input  ADDR_WIDTH  word address for reads.
- ReadBus  output  DATA_WIDTH  combinational read data.

Behaviour:
- Storage is a DEPTH x DATA_WIDTH array named Register, indexed 0..DEPTH-1.
  - The array is hierarchically accessible so benches can preload it with $readmemh(file, inst.Register).
- Reset is asynchronous and active-high.
  - Rising reset clears every word to 0 immediately, without waiting for a clock edge.
  - While reset is high, the array stays 0 and writes are ignored.
  - ReadBus reads 0 for every address while reset is high.
  - Reset has priority over a simultaneous write.
- Write:
  - On a rising clock edge with reset low and WE=1: Register[WriteAddress] <= WriteBus.
  - WE=0: no change.
  - Writes are single-cycle; there is no handshake and no busy state.
- Read:
  - ReadBus = Register[ReadAddress], purely combinational with zero-cycle latency.
  - ReadBus follows ReadAddress changes within the same delta/cycle.
- Read-during-write to the same address:
  - Before the edge, ReadBus shows the old value.
  - After the edge, ReadBus shows the new value, in the same cycle as the write.
  - There is no bypass mux; this is a plain array.
- Out-of-range (address ≥ DEPTH, only possible when DEPTH < 2**ADDR_WIDTH):
  - Writes are dropped.
  - Reads return all zeros.
- Uninitialised words (no preload and no reset since power-up) read X in simulation; they are not sanitised.
- Back-to-back writes on consecutive cycles to any addresses are all committed in order. The last write to an address wins.
- No internal state other than the array; the block has no FSM.

Decomposition:
- Shared package sram_pkg holds:
  - GRAPH_WIDTH=128, WORK_WIDTH=128, OUT_WIDTH=16, IN_WIDTH=8, MEM_ADDR_WIDTH=13.
  - A helper function is_in_range(addr, depth).
- Instantiate a common sub-module sram_core, parameterized by NUM_READ (1 or 2) and HAS_WRITE (0/1).
  - It contains the Register array, the read muxes, the reset-clear loop and the write logic.
  - This block is sram_core with NUM_READ=1, HAS_WRITE=1.
- The read-only variants reuse sram_core with HAS_WRITE=0:
  - Their clock/WE are tied off.
  - Their reset does not clear preloaded contents.

Test Plan:
- Reset clear: preload Register[5]=16'hBEEF, assert reset mid-cycle with no clock edge → ReadBus at ReadAddress=5 is 16'h0000 immediately; after release it stays 0.
- Basic write/read: WE=1, WriteAddress=13'h0010, WriteBus=16'h1234, one rising edge, ReadAddress=13'h0010 → ReadBus=16'h1234. ReadAddress=13'h0011 → unchanged value.
- WE low: WE=0, WriteBus=16'hFFFF to 13'h0010, one edge → ReadBus still 16'h1234.
- Read-during-write: ReadAddress=WriteAddress=13'h0020 holding 16'h0001, write 16'h0002 → ReadBus=16'h0001 before the edge and 16'h0002 after it, same cycle.
- Back-to-back: write 16'hAAAA, 16'hBBBB, 16'hCCCC to addresses 0, 8191, 0 on three consecutive edges → Register[0]=16'hCCCC, Register[8191]=16'hBBBB.
- Reset vs write priority: assert reset with WE=1, WriteAddress=3, WriteBus=16'h5555 across an edge → Register[3]=0 after reset release.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and helpers for the Bellman-Ford engine memories.
package sram_pkg;

    localparam int unsigned GRAPH_WIDTH    = 128;
    localparam int unsigned WORK_WIDTH     = 128;
    localparam int unsigned OUT_WIDTH      = 16;
    localparam int unsigned IN_WIDTH       = 8;
    localparam int unsigned MEM_ADDR_WIDTH = 13;

    function automatic logic is_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/sram_core.sv
// Common storage for the sram family: Register array, combinational read ports and
// optional synchronous write port with asynchronous clear.
module sram_core
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DEPTH      = 8192,
    parameter int unsigned NUM_READ   = 1,
    parameter bit          HAS_WRITE  = 1'b1
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_we,
    input  logic [ADDR_WIDTH-1:0]               i_waddr,
    input  logic [DATA_WIDTH-1:0]               i_wdata,
    input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0] i_raddr,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] Register [DEPTH];

    if (HAS_WRITE) begin : g_write
        logic w_wr_ok;
        assign w_wr_ok = i_we && is_in_range(32'(i_waddr), DEPTH);

        // Clear is level-sensitive in effect: any edge while reset is high re-clears.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                Register <= '{default: '0};
            end else if (w_wr_ok) begin
                Register[i_waddr] <= i_wdata;
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        assign o_rdata[p] = is_in_range(32'(i_raddr[p]), DEPTH) ? Register[i_raddr[p]] : '0;
    end

endmodule

// File: rtl/sram_1r1w.sv
// Output Memory of the Bellman-Ford engine: one combinational read port, one
// synchronous write port, asynchronous active-high clear.
module sram_1r1w
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OUT_WIDTH,
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 2 ** MEM_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WriteAddress,
    input  logic [DATA_WIDTH-1:0] WriteBus,
    input  logic [ADDR_WIDTH-1:0] ReadAddress,
    output logic [DATA_WIDTH-1:0] ReadBus
);

    sram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .NUM_READ   (1),
        .HAS_WRITE  (1'b1)
    ) u_core (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_we    (WE),
        .i_waddr (WriteAddress),
        .i_wdata (WriteBus),
        .i_raddr (ReadAddress),
        .o_rdata (ReadBus)
    );

endmodule

// File: tb/tb_sram_1r1w.sv
// Directed bench for sram_1r1w; expected reads are queued and checked by a monitor.
module tb_sram_1r1w;

    logic        clock = 1'b0;
    logic        reset;
    logic        WE;
    logic [12:0] WriteAddress;
    logic [15:0] WriteBus;
    logic [12:0] ReadAddress;
    logic [15:0] ReadBus;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
        string       name;
    } exp_t;

    exp_t q_exp[$];
    event ev_sample;
    int   tests_run = 0;
    int   tests_failed = 0;

    sram_1r1w dut (
        .clock        (clock),
        .reset        (reset),
        .WE           (WE),
        .WriteAddress (WriteAddress),
        .WriteBus     (WriteBus),
        .ReadAddress  (ReadAddress),
        .ReadBus      (ReadBus)
    );

    always #5 clock = ~clock;

    // Monitor: each sample strobe means ReadBus is presenting a value to check.
    initial begin
        exp_t e;
        forever begin
            @(ev_sample);
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                tests_run++;
                if (ReadBus !== e.data) begin
                    tests_failed++;
                    $display("FAIL %s: addr=%h ReadBus=%h expected=%h", e.name, e.addr,
                             ReadBus, e.data);
                end
            end
        end
    end

    task automatic check_read(input logic [12:0] addr, input logic [15:0] exp_data,
                              input string name);
        exp_t e;
        ReadAddress = addr;
        #1;
        e.addr = addr;
        e.data = exp_data;
        e.name = name;
        q_exp.push_back(e);
        -> ev_sample;
        #1;
    endtask

    task automatic do_write(input logic [12:0] addr, input logic [15:0] data);
        @(negedge clock);
        WE           = 1'b1;
        WriteAddress = addr;
        WriteBus     = data;
        @(posedge clock);
        #1;
        WE = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        WE           = 1'b0;
        WriteAddress = '0;
        WriteBus     = '0;
        ReadAddress  = '0;
        #2;
        check_read(13'h0000, 16'h0000, "reset_addr0");
        check_read(13'h0005, 16'h0000, "reset_addr5");
        @(negedge clock);
        reset = 1'b0;

        // Asynchronous clear mid-cycle, no clock edge involved
        do_write(13'h0005, 16'hBEEF);
        check_read(13'h0005, 16'hBEEF, "preload5");
        reset = 1'b1;
        check_read(13'h0005, 16'h0000, "async_clear5");
        check_read(13'h1FFF, 16'h0000, "in_reset_read");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_read(13'h0005, 16'h0000, "after_release5");

        // Basic write/read
        do_write(13'h0010, 16'h1234);
        check_read(13'h0010, 16'h1234, "basic_wr");
        check_read(13'h0011, 16'h0000, "neighbour");

        // WE low leaves contents alone
        @(negedge clock);
        WriteAddress = 13'h0010;
        WriteBus     = 16'hFFFF;
        WE           = 1'b0;
        @(posedge clock);
        #1;
        check_read(13'h0010, 16'h1234, "we_low");

        // Read-during-write, same address
        do_write(13'h0020, 16'h0001);
        @(negedge clock);
        WE           = 1'b1;
        WriteAddress = 13'h0020;
        WriteBus     = 16'h0002;
        check_read(13'h0020, 16'h0001, "rdw_before");
        @(posedge clock);
        #1;
        WE = 1'b0;
        check_read(13'h0020, 16'h0002, "rdw_after");

        // Back-to-back writes, last write to an address wins
        @(negedge clock);
        WE = 1'b1; WriteAddress = 13'h0000; WriteBus = 16'hAAAA;
        @(posedge clock); #1;
        WriteAddress = 13'h1FFF; WriteBus = 16'hBBBB;
        @(posedge clock); #1;
        WriteAddress = 13'h0000; WriteBus = 16'hCCCC;
        @(posedge clock); #1;
        WE = 1'b0;
        check_read(13'h0000, 16'hCCCC, "b2b_addr0");
        check_read(13'h1FFF, 16'hBBBB, "b2b_addr8191");

        // Reset beats a simultaneous write
        do_write(13'h0003, 16'h7777);
        check_read(13'h0003, 16'h7777, "pre_prio3");
        @(negedge clock);
        WE = 1'b1; WriteAddress = 13'h0003; WriteBus = 16'h5555;
        reset = 1'b1;
        @(posedge clock); #1;
        check_read(13'h0003, 16'h0000, "prio_in_reset");
        @(negedge clock);
        WE    = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        check_read(13'h0003, 16'h0000, "prio_after");
        check_read(13'h0010, 16'h0000, "cleared_0010");
        check_read(13'h1FFF, 16'h0000, "cleared_8191");

        do_write(13'h0003, 16'h5555);
        check_read(13'h0003, 16'h5555, "post_reset_wr");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 100 && q_exp.size() != 0; i++) @(posedge clock);
        if (q_exp.size() != 0) begin
            $display("FAIL drain: pending=%0d expected=0", q_exp.size());
            tests_run    += q_exp.size();
            tests_failed += q_exp.size();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
